// File: rtl/wta_pwm_if.sv
// Pin bundle of the winner-take-all PWM block: level/strobe inputs, PWM and status outputs.
// Latency: none; plain wires between the driver and the block.
// Backpressure: none; loads are fire-and-forget, one per cycle.
interface wta_pwm_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    // Driver side: supplies levels and strobes, observes PWM/status.
    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uio_out,
        input  uio_oe,
        input  uo_out
    );

    // Block side.
    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uio_out,
        output uio_oe,
        output uo_out
    );
endinterface

// File: rtl/wta_pwm.sv
// Winner-take-all PWM: four levels compete, the largest drives a 256-cycle PWM on its own pin.
// Latency: a load is visible in the duty at the next period boundary (at most 257 cycles).
// Backpressure: none; a load strobe is accepted every cycle, later loads overwrite.
module wta_pwm #(
    parameter int CNT_W = 8,
    parameter int N_CH  = 4
) (
    input  logic         clk,
    input  logic         rst_n,    // active-high synchronous reset despite the name
    wta_pwm_if.slave     bus
);
    localparam int IDX_W = $clog2(N_CH);

    logic [CNT_W-1:0] lvl_q [N_CH];
    logic [CNT_W-1:0] lvl_d [N_CH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic [CNT_W-1:0] win_lvl_q, win_lvl_d;

    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] best_lvl;
    logic             pwm;
    logic [N_CH-1:0]  ch_pwm;
    logic             load;
    logic [IDX_W-1:0] load_sel;

    // ena and the spare uio_in bits carry no meaning for this block.
    logic unused_in;
    assign unused_in = ^{bus.ena, bus.uio_in[7:3]};

    assign load     = bus.uio_in[2];
    assign load_sel = bus.uio_in[IDX_W-1:0];

    // Largest registered level wins; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_lvl = lvl_q[0];
        for (int i = 1; i < N_CH; i++) begin
            if (lvl_q[i] > best_lvl) begin
                best_lvl = lvl_q[i];
                best_idx = IDX_W'(i);
            end
        end
    end

    // Next state: free-running counter, level writes, winner latched only at the period boundary.
    always_comb begin
        lvl_d     = lvl_q;
        cnt_d     = cnt_q + 1'b1;
        win_idx_d = win_idx_q;
        win_lvl_d = win_lvl_q;
        if (load) begin
            lvl_d[load_sel] = bus.ui_in[CNT_W-1:0];
        end
        // Uses pre-edge levels, so a load on the boundary edge waits one more period.
        if (cnt_q == '1) begin
            win_idx_d = best_idx;
            win_lvl_d = best_lvl;
        end
    end

    // State registers; reset overrides loading and counting.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                lvl_q[i] <= '0;
            end
            cnt_q     <= '0;
            win_idx_q <= '0;
            win_lvl_q <= '0;
        end else begin
            lvl_q     <= lvl_d;
            cnt_q     <= cnt_d;
            win_idx_q <= win_idx_d;
            win_lvl_q <= win_lvl_d;
        end
    end

    // Duty equals win_lvl; 255 still leaves cnt=255 low, so 100% is never reached.
    assign pwm = (cnt_q < win_lvl_q);

    // Only the winning channel's pin carries the PWM.
    always_comb begin
        ch_pwm = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_pwm[k] = pwm && (win_idx_q == IDX_W'(k));
        end
    end

    assign bus.uo_out  = {(cnt_q == '0), pwm, win_idx_q, ch_pwm};
    assign bus.uio_out = {win_lvl_q[CNT_W-1 -: 4], 4'b0000};
    assign bus.uio_oe  = 8'hF0;
endmodule

// File: tb/tb_wta_pwm.sv
// Randomised and directed stimulus for wta_pwm, checked by a cycle scoreboard and period duty counts.
// Latency: expected pin state for each edge is queued when the stimulus is applied.
// Backpressure: none; the monitor pops one entry per clock.
module tb_wta_pwm;
    logic clk = 1'b0;
    logic rst_n;
    wta_pwm_if bus ();

    wta_pwm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [23:0] exp_q [$];

    // Reference state, kept as plain integers.
    int m_lvl [4];
    int m_cnt;
    int m_widx;
    int m_wlvl;

    // Per-bit high-cycle counts of uo_out over a measured window.
    int hi [8];
    int last_uo;

    function automatic int ref_winner_idx();
        int mx = 0;
        for (int i = 0; i < 4; i++) if (m_lvl[i] > mx) mx = m_lvl[i];
        for (int i = 0; i < 4; i++) if (m_lvl[i] == mx) return i;
        return 0;
    endfunction

    function automatic logic [23:0] ref_pins();
        int pwm, uo, uio;
        pwm = (m_cnt < m_wlvl) ? 1 : 0;
        uo  = ((m_cnt == 0) ? 128 : 0) + pwm * 64 + m_widx * 16 + (pwm != 0 ? (1 << m_widx) : 0);
        uio = (m_wlvl / 16) * 16;
        return {8'hF0, uio[7:0], uo[7:0]};
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Apply one clock of stimulus, advance the model across the edge, queue the expected pins.
    task automatic cycle(input bit r, input bit ld, input int ch, input int val);
        int wi;
        rst_n       = r;
        bus.ui_in   = 8'(val);
        bus.uio_in  = {$urandom_range(0, 31) , ld, 2'(ch)};
        bus.ena     = $urandom_range(0, 1);
        if (r) begin
            for (int i = 0; i < 4; i++) m_lvl[i] = 0;
            m_cnt = 0; m_widx = 0; m_wlvl = 0;
        end else begin
            if (m_cnt == 255) begin
                wi     = ref_winner_idx();
                m_widx = wi;
                m_wlvl = m_lvl[wi];
            end
            if (ld) m_lvl[ch] = val;
            m_cnt = (m_cnt + 1) % 256;
        end
        exp_q.push_back(ref_pins());
        @(negedge clk);
        for (int b = 0; b < 8; b++) if (bus.uo_out[b]) hi[b]++;
        last_uo = bus.uo_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic clear_hi();
        for (int b = 0; b < 8; b++) hi[b] = 0;
    endtask

    // Run until the next edge is the period boundary.
    task automatic to_boundary();
        while (m_cnt != 255) cycle(0, 0, 0, 0);
    endtask

    task automatic measure_period();
        clear_hi();
        idle(256);
    endtask

    // Scoreboard monitor: one expected pin word per clock edge.
    always @(posedge clk) begin
        logic [23:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if ({bus.uio_oe, bus.uio_out, bus.uo_out} !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got=%h want=%h", $time,
                         {bus.uio_oe, bus.uio_out, bus.uo_out}, e);
            end
        end
    end

    initial begin
        rst_n = 1'b1; bus.ena = 1'b1; bus.ui_in = '0; bus.uio_in = '0;
        for (int i = 0; i < 4; i++) m_lvl[i] = 0;
        m_cnt = 0; m_widx = 0; m_wlvl = 0;
        clear_hi();

        // Reset, then a quiet period: no PWM, exactly one period pulse.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("reset_uo_out", last_uo, 8'h80);
        check("reset_uio_out", bus.uio_out, 0);
        check("reset_uio_oe", bus.uio_oe, 8'hF0);
        clear_hi();
        idle(256);
        check("idle_pwm_high", hi[6], 0);
        check("idle_pulses", hi[7], 1);

        // Single channel at 64.
        cycle(0, 1, 2, 64);
        to_boundary();
        measure_period();
        check("single_idx", (last_uo >> 4) & 3, 2);
        check("single_ch2_high", hi[2], 64);
        check("single_other_high", hi[0] + hi[1] + hi[3], 0);
        check("single_uio_out", bus.uio_out, 8'h40);

        // Competition with a tie at 200: lowest index wins.
        cycle(0, 1, 0, 100);
        cycle(0, 1, 1, 200);
        cycle(0, 1, 2, 200);
        cycle(0, 1, 3, 50);
        to_boundary();
        measure_period();
        check("tie_idx", (last_uo >> 4) & 3, 1);
        check("tie_ch1_high", hi[1], 200);
        check("tie_pwm_high", hi[6], 200);
        cycle(0, 1, 1, 10);
        to_boundary();
        measure_period();
        check("retie_idx", (last_uo >> 4) & 3, 2);
        check("retie_ch2_high", hi[2], 200);

        // Load on the boundary edge itself is deferred by one period.
        to_boundary();
        clear_hi();
        cycle(0, 1, 3, 255);
        idle(255);
        check("bnd_old_idx", (last_uo >> 4) & 3, 2);
        check("bnd_old_high", hi[2], 200);
        check("bnd_ch3_early", hi[3], 0);
        measure_period();
        check("bnd_new_idx", (last_uo >> 4) & 3, 3);
        check("bnd_ch3_high", hi[3], 255);

        // All-zero levels: index 0, nothing high.
        for (int i = 0; i < 4; i++) cycle(0, 1, i, 0);
        to_boundary();
        measure_period();
        check("zero_idx", (last_uo >> 4) & 3, 0);
        check("zero_high", hi[0] + hi[1] + hi[2] + hi[3] + hi[6], 0);
        cycle(0, 1, 0, 1);
        to_boundary();
        measure_period();
        check("one_high", hi[0], 1);

        // Reset mid-period with a 128 winner: everything cleared afterwards.
        cycle(0, 1, 1, 128);
        to_boundary();
        idle(91);
        cycle(1, 0, 0, 0);
        check("midrst_uo_out", last_uo, 8'h80);
        measure_period();
        check("midrst_pwm_high", hi[6], 0);

        // Random loads and rare resets, scoreboard only.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0)
                cycle(1, 0, 0, 0);
            else if ($urandom_range(0, 9) == 0)
                cycle(0, 1, $urandom_range(0, 3), $urandom_range(0, 255));
            else
                cycle(0, 0, 0, 0);
        end

        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
